// File: rtl/fm_modulator_pkg.sv
// Shared quantization constants, FSM state type and the quarter-wave sine
// table builder for the FM transmit path.
package fm_modulator_pkg;

  localparam int BITS            = 10;
  localparam int QUANT_VAL       = 1 << BITS;
  localparam int ADUIO_DECIM     = 8;
  localparam int PHASE_BITS      = 16;
  localparam int FM_GAIN         = 8192;
  localparam int SIN_LUT_ENTRIES = 257;
  localparam int LUT_ADDR_BITS   = 10;
  localparam int SAMPLE_W        = BITS + 2;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fm_state_t;

  typedef logic [BITS:0] sin_lut_t [SIN_LUT_ENTRIES];

  function automatic int quantize_f(input real x);
    return int'(x * real'(QUANT_VAL));
  endfunction

  // Taylor series keeps elaboration independent of tool math libraries;
  // ten terms are far below one LSB of error over [0, pi/2].
  function automatic real quarter_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic sin_lut_t build_sin_lut();
    sin_lut_t t;
    for (int k = 0; k < SIN_LUT_ENTRIES; k++) begin
      t[k] = (BITS + 1)'(quantize_f(quarter_sin(PI / 2.0 * real'(k) / 256.0)));
    end
    return t;
  endfunction

endpackage

// File: rtl/fm_sin_lut.sv
// Quarter-wave sine table with quadrant-mapped sin and cos read ports and a
// registered, enabled output stage that doubles as the block output register.
module fm_sin_lut
  import fm_modulator_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  input  logic [LUT_ADDR_BITS-1:0]     idx,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q
);

  localparam sin_lut_t SIN_TABLE = build_sin_lut();

  logic [LUT_ADDR_BITS-1:0] cos_idx;
  logic signed [SAMPLE_W-1:0] sin_val;
  logic signed [SAMPLE_W-1:0] cos_val;

  // Odd quadrants read the table mirrored, the upper half negates.
  function automatic logic signed [SAMPLE_W-1:0] quad_sin(input logic [LUT_ADDR_BITS-1:0] x);
    logic [8:0] addr;
    logic signed [SAMPLE_W-1:0] mag;
    addr = x[8] ? (9'd256 - {1'b0, x[7:0]}) : {1'b0, x[7:0]};
    mag  = signed'({1'b0, SIN_TABLE[addr]});
    return x[9] ? -mag : mag;
  endfunction

  assign cos_idx = idx + 10'd256;
  assign sin_val = quad_sin(idx);
  assign cos_val = quad_sin(cos_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_i <= '0;
      out_q <= '0;
    end else if (en) begin
      out_i <= {{(DATA_WIDTH - SAMPLE_W){cos_val[SAMPLE_W-1]}}, cos_val};
      out_q <= {{(DATA_WIDTH - SAMPLE_W){sin_val[SAMPLE_W-1]}}, sin_val};
    end
  end

endmodule

// File: rtl/fm_modulator.sv
// Baseband FM modulator: clamps and scales audio, holds each sample for
// ADUIO_DECIM IQ periods while integrating it into phase, and maps phase to I/Q.
module fm_modulator #(
  parameter int DATA_WIDTH = 32,
  parameter int PHASE_BITS = fm_modulator_pkg::PHASE_BITS,
  parameter int GAIN       = fm_modulator_pkg::FM_GAIN
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q,
  output logic                         out_valid,
  input  logic                         out_ready
);

  import fm_modulator_pkg::*;

  localparam int CNT_W = $clog2(ADUIO_DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADUIO_DECIM - 1);
  localparam logic signed [DATA_WIDTH-1:0] Q_POS = DATA_WIDTH'(QUANT_VAL);
  localparam logic signed [DATA_WIDTH-1:0] Q_NEG = -Q_POS;
  localparam logic signed [31:0] GAIN_S = 32'(GAIN);

  fm_state_t             state;
  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS-1:0] phase_next;
  logic [PHASE_BITS-1:0] delta_q;
  logic [PHASE_BITS-1:0] delta_new;
  logic [CNT_W-1:0]      cnt;
  logic signed [31:0]    clamped;
  logic signed [31:0]    scaled;
  logic                  advance;
  logic                  issue;
  logic                  last_issue;
  logic                  accept;

  // NOTE: every branch assigns clamped, so this stays pure combinational logic.
  always_comb begin
    clamped = 32'(in_data);
    if (in_data > Q_POS) begin
      clamped = 32'(Q_POS);
    end else if (in_data < Q_NEG) begin
      clamped = 32'(Q_NEG);
    end
  end

  assign scaled    = (clamped * GAIN_S) >>> BITS;
  assign delta_new = PHASE_BITS'(scaled);

  assign advance    = !out_valid || out_ready;
  assign issue      = (state == RUN) && advance;
  assign last_issue = issue && (cnt == CNT_LAST);
  assign in_ready   = (state == IDLE) || last_issue;
  assign accept     = in_valid && in_ready;
  assign phase_next = phase + delta_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      delta_q   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= (state == RUN);
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            delta_q <= delta_new;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            phase <= phase_next;
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (accept) begin
                delta_q <= delta_new;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fm_sin_lut #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lut (
    .clock (clock),
    .reset (reset),
    .en    (issue),
    .idx   (phase_next[PHASE_BITS-1 -: LUT_ADDR_BITS]),
    .out_i (out_i),
    .out_q (out_q)
  );

endmodule

// File: tb/tb_fm_modulator.sv
// Scoreboard bench for fm_modulator: a trigonometric reference model predicts
// each accepted sample's IQ burst; a monitor compares whatever the DUT hands over.
module tb_fm_modulator;

  localparam int DW    = 32;
  localparam int GAIN  = 8192;
  localparam int QV    = 1024;
  localparam int DECIM = 8;
  localparam real PI   = 3.14159265358979323846;

  logic                 clock = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic                 out_valid;
  logic                 out_ready;

  typedef struct {
    int i;
    int q;
  } iq_t;

  iq_t exp_q[$];
  int  obs_i[$];
  int  obs_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  model_phase = 0;
  bit  stalled = 1'b0;
  int  prev_i, prev_q;

  fm_modulator #(
    .DATA_WIDTH(DW),
    .PHASE_BITS(16),
    .GAIN      (GAIN)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_i    (out_i),
    .out_q    (out_q),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference: phase advances by the scaled audio value per IQ sample; I/Q are
  // the rounded cosine/sine of the top ten phase bits as an angle.
  function automatic void model_accept(input int x);
    int c, delta, idx;
    real ang;
    c = (x > QV) ? QV : (x < -QV) ? -QV : x;
    delta = (c * GAIN) / QV;
    for (int k = 0; k < DECIM; k++) begin
      model_phase = (model_phase + delta + 65536) % 65536;
      idx = model_phase / 64;
      ang = 2.0 * PI * real'(idx) / 1024.0;
      exp_q.push_back('{int'($cos(ang) * QV), int'($sin(ang) * QV)});
    end
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      model_phase = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_i", out_i, prev_i);
        check("stall_q", out_q, prev_q);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          iq_t e;
          e = exp_q.pop_front();
          check("sb_out_i", out_i, e.i);
          check("sb_out_q", out_q, e.q);
        end
        obs_i.push_back(out_i);
        obs_q.push_back(out_q);
      end
      stalled = out_valid && !out_ready;
      prev_i  = out_i;
      prev_q  = out_q;
      if (in_valid && in_ready) model_accept(in_data);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input int x, input bit keep);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int t = 0; t < 200; t++) begin
      #1;
      got = in_ready;
      step();
      if (got) break;
    end
    if (!keep) in_valid = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_obs(input string name, input int k, input int ei, input int eq);
    check({name, "_i"}, (obs_i.size() > k) ? obs_i[k] : 99999, ei);
    check({name, "_q"}, (obs_q.size() > k) ? obs_q[k] : 99999, eq);
  endtask

  task automatic check_plus_burst(input string name);
    check({name, "_count"}, obs_i.size(), DECIM);
    check_obs({name, "_o1"}, 0, 724, 724);
    check_obs({name, "_o2"}, 1, 0, 1024);
    check_obs({name, "_o4"}, 3, -1024, 0);
    check_obs({name, "_o8"}, 7, 1024, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int max_run, run;
    bit rand_done;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    step();

    // Zero audio: constant phase, in_ready only on the last issue.
    obs_i.delete(); obs_q.delete();
    send(0, 1'b0);
    for (int k = 0; k < DECIM; k++) begin
      #1;
      check($sformatf("zero_in_ready_%0d", k), in_ready, (k == DECIM - 1) ? 1 : 0);
      step();
    end
    drain();
    check("zero_count", obs_i.size(), DECIM);
    for (int k = 0; k < obs_i.size(); k++) check_obs($sformatf("zero_o%0d", k), k, 1024, 0);

    obs_i.delete(); obs_q.delete();
    send(1024, 1'b0);
    drain();
    check_plus_burst("plus");

    obs_i.delete(); obs_q.delete();
    send(5000, 1'b0);
    drain();
    check_plus_burst("clamp");

    obs_i.delete(); obs_q.delete();
    send(-1024, 1'b0);
    drain();
    check_obs("neg_o1", 0, 724, -724);

    // Backpressure mid-burst.
    obs_i.delete(); obs_q.delete();
    send(1024, 1'b0);
    repeat (3) step();
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    drain();
    check_plus_burst("stall");

    // Back-to-back inputs with in_valid held.
    max_run = 0; run = 0;
    fork
      begin
        send(0, 1'b1);
        send(1024, 1'b0);
      end
      begin
        for (int t = 0; t < 30; t++) begin
          @(negedge clock);
          run = out_valid ? run + 1 : 0;
          if (run > max_run) max_run = run;
        end
      end
    join
    drain();
    check("b2b_run", max_run, 2 * DECIM);

    // Reset while output 3 is presented.
    obs_i.delete(); obs_q.delete();
    send(1024, 1'b0);
    for (int t = 0; t < 50; t++) begin
      if (obs_i.size() >= 2) break;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_i", out_i, 0);
    check("midrst_in_ready", in_ready, 1);
    step();
    obs_i.delete(); obs_q.delete();
    send(1024, 1'b0);
    drain();
    check_plus_burst("after_rst");

    // Randomized traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(2)) step();
          send(int'($urandom_range(6000)) - 3000, 1'b0);
        end
        rand_done = 1'b1;
      end
      begin
        for (int t = 0; t < 5000 && !rand_done; t++) begin
          out_ready = ($urandom_range(3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
